fetch_queue: RTL and testbench

Instruction fetch queue sitting between the fetch stage and decode in the pipelined core. It tracks the address the fetch stage presents to the instruction ROM and captures the returned word one cycle later. It buffers (pc, instruction) pairs in a small FIFO and hands them to decode through a valid/ready handshake. It flushes wrong-path instructions on a jump and back-pressures fetch when full.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_queue.sv | 66 ++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared core definitions used by the fetch queue: the NOP encoding and the
// (pc, instr) entry layout stored in the fetch FIFO.
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetch entries with a synchronous flush.
// The head is read straight from storage; callers mux it when count is zero.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  entry,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode queue: tracks the in-flight ROM request, buffers returned
// (pc, instr) pairs, flushes on jump and back-pressures fetch by credit.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        jump,
    output logic        fetch_hold,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          inflight_v;
    logic [31:0]   inflight_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          push;
    logic          pop;
    fetch_entry_t  entry;
    fetch_entry_t  head;

    // Decode handshake: the head transfers on any cycle with id_valid && id_ready;
    // id_valid never depends on id_ready, and a jump cancels the transfer.
    assign id_valid = (count != '0);
    assign id_pc    = id_valid ? head.pc    : 32'd0;
    assign id_instr = id_valid ? head.instr : NOP_INSTR;

    assign pop   = id_valid && id_ready && !jump;
    assign push  = inflight_v && !jump;
    assign entry = '{pc: inflight_pc, instr: i_data};

    // Credit counts the in-flight request so a returning word always has a slot.
    assign occupancy  = count + CW'(inflight_v);
    assign fetch_hold = (occupancy == CW'(DEPTH)) && !(id_valid && id_ready) && !jump;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_v  <= 1'b0;
            inflight_pc <= 32'd0;
        end else begin
            inflight_v  <= !fetch_hold;
            inflight_pc <= i_addr;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (jump),
        .entry   (entry),
        .head    (head),
        .count   (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a fetch/ROM model drives the queue while a
// scoreboard of outstanding request pcs checks every decode transfer.
module tb_fetch_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        jump;
    logic        fetch_hold;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pc;
    logic        s_valid;
    logic        s_hold;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [23:0] pat;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .jump       (jump),
        .fetch_hold (fetch_hold),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_ready   (id_ready)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(id_valid), 32'd0);
        check({tag, "_instr"}, id_instr, NOP);
        check({tag, "_pc"}, id_pc, 32'd0);
        check({tag, "_hold"}, 32'(fetch_hold), 32'd0);
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge
    // with reset released and the fetch model back at PC 0.
    task automatic apply_reset();
        reset_n  = 1'b0;
        jump     = 1'b0;
        id_ready = 1'b0;
        i_addr   = 32'd0;
        i_data   = 32'd0;
        pc       = 32'd0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
    endtask

    // ---------------- driver + scoreboard ----------------
    // One pipeline cycle: drive at the falling edge, sample #1 later, let the
    // rising edge happen, return at the next falling edge.
    task automatic step(input logic rdy, input logic jmp, input logic [31:0] tgt);
        logic [31:0] exp_pc;
        i_data   = rom(i_addr);
        id_ready = rdy;
        jump     = jmp;
        i_addr   = jmp ? tgt : pc;
        #1;
        s_valid = id_valid;
        s_hold  = fetch_hold;
        s_pc    = id_pc;
        s_instr = id_instr;

        if (jmp) begin
            exp_q.delete();
        end else if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_spurious_valid", 32'(id_valid), 32'd0);
            end else begin
                exp_pc = exp_q.pop_front();
                check("sb_pc", id_pc, exp_pc);
                check("sb_instr", id_instr, rom(exp_pc));
            end
        end
        if (!fetch_hold) begin
            exp_q.push_back(i_addr);
            pc = i_addr + 32'd4;
        end
        check("credit_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
        check("fifo_count_bound", 32'(dut.u_fifo.count <= DEPTH), 32'd1);

        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    initial begin
        reset_n  = 1'b0;
        jump     = 1'b0;
        id_ready = 1'b0;
        i_addr   = 32'd0;
        i_data   = 32'd0;
        pc       = 32'd0;
        pat      = 24'b1101_0011_1001_1110_0101_1011;
        @(negedge clk);

        // Streaming with decode always ready: 2-cycle latency then one per cycle.
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 32'd0);
            check("stream_hold", 32'(s_hold), 32'd0);
            if (i < 2) begin
                check("stream_valid_early", 32'(s_valid), 32'd0);
                check("stream_instr_empty", s_instr, NOP);
            end else begin
                check("stream_valid", 32'(s_valid), 32'd1);
                check("stream_pc", s_pc, 32'(4 * (i - 2)));
            end
        end

        // Decode stalled from reset: fills with pc 0, 4 then holds fetch.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0);
            check("stall_hold", 32'(s_hold), 32'(i >= 2));
            if (i >= 2) check("stall_head_pc", s_pc, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0);
            check("drain_valid", 32'(s_valid), 32'd1);
            check("drain_pc", s_pc, 32'(4 * i));
            check("drain_hold", 32'(s_hold), 32'd0);
        end

        // Jump with pc 8 buffered and 12 in flight, decode not ready.
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h100);
        check("jmp_cycle_pc", s_pc, 32'd8);
        check("jmp_cycle_hold", 32'(s_hold), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("jmp_next_valid", 32'(s_valid), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("jmp_tgt_valid", 32'(s_valid), 32'd1);
        check("jmp_tgt_pc", s_pc, 32'h100);
        check("jmp_tgt_instr", s_instr, rom(32'h100));
        step(1'b1, 1'b0, 32'd0);
        check("jmp_tgt_plus4", s_pc, 32'h104);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);

        // Jump while full with decode ready: head is discarded, not consumed.
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h200);
        check("jfull_hold", 32'(s_hold), 32'd0);
        check("jfull_head_pc", s_pc, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("jfull_next_valid", 32'(s_valid), 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("jfull_tgt_pc", s_pc, 32'h200);
        step(1'b1, 1'b0, 32'd0);
        check("jfull_tgt_plus4", s_pc, 32'h204);

        // Irregular decode back-pressure; scoreboard checks order and content.
        apply_reset();
        for (int i = 0; i < 24; i++) step(pat[i], 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);

        // Asynchronous reset mid-stream with entries buffered.
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        check_reset_outputs("async_reset_hold");
        pc     = 32'd0;
        i_addr = 32'd0;
        exp_q.delete();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0);
            if (i < 2) check("post_reset_valid", 32'(s_valid), 32'd0);
            else       check("post_reset_pc", s_pc, 32'(4 * (i - 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
